// File: rtl/uart_str_tx.sv
// 8N1 UART string transmitter: sends nummax bytes of a right-aligned packed string,
// highest byte first, LSB first within each byte, with an integer clocks-per-bit divider.
`timescale 1ns/1ps
module uart_str_tx #(
    parameter int unsigned CLK_DIV   = 703,
    parameter int unsigned MAX_BYTES = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_uart,
    input  logic [8*MAX_BYTES-1:0] read_data,
    input  logic [5:0]             nummax,
    output logic                   txd,
    output logic                   busy,
    output logic                   tx_done
);

    localparam int unsigned BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW = 8 * MAX_BYTES;
    localparam logic [BW-1:0] BaudLast = BW'(CLK_DIV - 1);
    localparam logic [5:0] MaxBytes = 6'(MAX_BYTES);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [5:0]    byte_cnt_q, byte_cnt_d;
    logic [SW-1:0] str_q, str_d;
    logic          txd_q, txd_d;
    logic          busy_q, busy_d;
    logic          tx_done_q, tx_done_d;

    logic [5:0]    num_clamped;
    logic [5:0]    byte_idx;
    logic [SW-1:0] str_shifted;
    logic [7:0]    cur_byte;
    logic [2:0]    bit_next;
    logic          baud_last;

    always_comb begin
        num_clamped = (nummax > MaxBytes) ? MaxBytes : nummax;
        byte_idx    = byte_cnt_q - 6'd1;
        // Current byte is the one at index byte_cnt-1; first character sits highest.
        str_shifted = str_q >> {byte_idx, 3'b000};
        cur_byte    = str_shifted[7:0];
        bit_next    = bit_idx_q + 3'd1;
        baud_last   = (baud_q == BaudLast);
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        str_d      = str_q;
        txd_d      = txd_q;
        busy_d     = busy_q;
        tx_done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (en_uart && (num_clamped != 6'd0)) begin
                    str_d      = read_data;
                    byte_cnt_d = num_clamped;
                    baud_d     = '0;
                    txd_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (baud_last) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    txd_d     = cur_byte[0];
                    state_d   = StData;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StData: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_next;
                        txd_d     = cur_byte[bit_next];
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            StStop: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (byte_cnt_q > 6'd1) begin
                        // Next byte's start bit follows the stop bit with no gap.
                        byte_cnt_d = byte_cnt_q - 6'd1;
                        txd_d      = 1'b0;
                        state_d    = StStart;
                    end else begin
                        byte_cnt_d = 6'd0;
                        txd_d      = 1'b1;
                        busy_d     = 1'b0;
                        tx_done_d  = 1'b1;
                        state_d    = StIdle;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            byte_cnt_q <= 6'd0;
            str_q      <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            str_q      <= str_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign tx_done = tx_done_q;

endmodule

// File: tb/tb_uart_str_tx.sv
// Directed bench for uart_str_tx: a CLK_DIV=4 instance for protocol checks and a
// CLK_DIV=703 instance decoded by a mid-bit sampling reference receiver.
`timescale 1ns/1ps
module tb_uart_str_tx;

    localparam int unsigned DivFast = 4;
    localparam int unsigned DivSlow = 703;
    localparam logic [79:0] StrShort = 80'h2A3123;
    localparam logic [79:0] StrLong  = 80'h2A4130382D325F563423;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_uart = 1'b0;
    logic        en_slow = 1'b0;
    logic [79:0] read_data = '0;
    logic [5:0]  nummax = '0;
    logic        txd, busy, tx_done;
    logic        txd_s, busy_s, done_s;

    int n_cmp = 0;
    int n_bad = 0;

    int   busy_cyc = 0;
    int   done_cnt = 0;
    int   fall_cnt = 0;
    logic txd_prev = 1'b1;

    always #5 clk = ~clk;

    uart_str_tx #(.CLK_DIV(DivFast), .MAX_BYTES(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_uart  (en_uart),
        .read_data(read_data),
        .nummax   (nummax),
        .txd      (txd),
        .busy     (busy),
        .tx_done  (tx_done)
    );

    uart_str_tx #(.CLK_DIV(DivSlow), .MAX_BYTES(10)) dut_slow (
        .clk      (clk),
        .rst      (rst),
        .en_uart  (en_slow),
        .read_data(read_data),
        .nummax   (nummax),
        .txd      (txd_s),
        .busy     (busy_s),
        .tx_done  (done_s)
    );

    // Activity counters on the fast instance, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cyc <= busy_cyc + 1;
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (txd_prev === 1'b1 && txd === 1'b0) fall_cnt <= fall_cnt + 1;
        txd_prev <= txd;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic start_fast(input logic [79:0] data, input logic [5:0] n);
        read_data = data;
        nummax    = n;
        en_uart   = 1'b1;
        @(negedge clk);
        en_uart = 1'b0;
    endtask

    // Reference receiver: samples mid-bit of one 40-cycle frame starting at the start edge.
    // Optionally pokes en_uart and scrambles read_data/nummax at cycle 'poke' of the frame.
    task automatic rx_frame(input int poke, output logic [9:0] bits);
        bits = '0;
        for (int t = 0; t < 10 * DivFast; t++) begin
            if (t == poke) begin
                en_uart   = 1'b1;
                read_data = {80{1'b1}};
                nummax    = 6'd10;
            end else if (t == poke + 1) begin
                en_uart = 1'b0;
            end
            if (t % DivFast == DivFast / 2) bits[t / DivFast] = txd;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({txd, busy, tx_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_fast: got txd/busy/done=%b want 100", {txd, busy, tx_done});
        end
        n_cmp++;
        if ({txd_s, busy_s, done_s} !== 3'b100) begin
            n_bad++;
            $display("FAIL reset_slow: got txd/busy/done=%b want 100", {txd_s, busy_s, done_s});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_short_string();
        logic [9:0] bits;
        logic [7:0] exp [3];
        int b0, d0;
        exp = '{8'h2A, 8'h31, 8'h23};
        b0 = busy_cyc;
        d0 = done_cnt;
        start_fast(StrShort, 6'd3);
        n_cmp++;
        if ({txd, busy} !== 2'b01) begin
            n_bad++;
            $display("FAIL short_accept: got txd/busy=%b want 01", {txd, busy});
        end
        for (int j = 0; j < 3; j++) begin
            rx_frame(-1, bits);
            n_cmp++;
            if (bits !== {1'b1, exp[j], 1'b0}) begin
                n_bad++;
                $display("FAIL short_frame%0d: got %b want %b", j, bits, {1'b1, exp[j], 1'b0});
            end
        end
        n_cmp++;
        if ({busy, tx_done, txd} !== 3'b011) begin
            n_bad++;
            $display("FAIL short_end: got busy/done/txd=%b want 011", {busy, tx_done, txd});
        end
        @(negedge clk);
        n_cmp++;
        if (tx_done !== 1'b0) begin
            n_bad++;
            $display("FAIL short_done_width: got tx_done=%b want 0", tx_done);
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy_cyc - b0 != 120 || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL short_counts: got busy=%0d done=%0d want busy=120 done=1",
                     busy_cyc - b0, done_cnt - d0);
        end
    endtask

    task automatic run_long(input logic [5:0] n, input string tag);
        logic [9:0] bits;
        logic [7:0] exp;
        int b0, d0;
        b0 = busy_cyc;
        d0 = done_cnt;
        start_fast(StrLong, n);
        for (int j = 0; j < 10; j++) begin
            exp = StrLong[79 - 8 * j -: 8];
            rx_frame(-1, bits);
            n_cmp++;
            if (bits !== {1'b1, exp, 1'b0}) begin
                n_bad++;
                $display("FAIL %s_frame%0d: got %b want %b", tag, j, bits, {1'b1, exp, 1'b0});
            end
        end
        n_cmp++;
        if ({busy, tx_done, txd} !== 3'b011) begin
            n_bad++;
            $display("FAIL %s_end: got busy/done/txd=%b want 011", tag, {busy, tx_done, txd});
        end
        repeat (10) @(negedge clk);
        n_cmp++;
        if (busy_cyc - b0 != 400 || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL %s_counts: got busy=%0d done=%0d want busy=400 done=1",
                     tag, busy_cyc - b0, done_cnt - d0);
        end
    endtask

    task automatic test_ignore_inputs();
        logic [9:0] bits;
        logic [7:0] exp [3];
        int b0, d0;
        exp = '{8'h2A, 8'h31, 8'h23};
        b0 = busy_cyc;
        d0 = done_cnt;
        start_fast(StrShort, 6'd3);
        for (int j = 0; j < 3; j++) begin
            rx_frame((j == 1) ? 10 : -1, bits);
            n_cmp++;
            if (bits !== {1'b1, exp[j], 1'b0}) begin
                n_bad++;
                $display("FAIL ignore_frame%0d: got %b want %b", j, bits, {1'b1, exp[j], 1'b0});
            end
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (busy_cyc - b0 != 120 || done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL ignore_counts: got busy=%0d done=%0d want busy=120 done=1",
                     busy_cyc - b0, done_cnt - d0);
        end
    endtask

    task automatic test_zero_and_clamp();
        int b0, d0, f0;
        b0 = busy_cyc;
        d0 = done_cnt;
        f0 = fall_cnt;
        start_fast(StrLong, 6'd0);
        repeat (20) @(negedge clk);
        n_cmp++;
        if (busy_cyc != b0 || done_cnt != d0 || fall_cnt != f0 || txd !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_len: got busy=%0d done=%0d falls=%0d txd=%b want 0 0 0 1",
                     busy_cyc - b0, done_cnt - d0, fall_cnt - f0, txd);
        end
        run_long(6'd20, "clamp");
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        logic [7:0] exp [3];
        int d0;
        exp = '{8'h2A, 8'h31, 8'h23};
        start_fast(StrShort, 6'd3);
        rx_frame(-1, bits);
        repeat (12) @(negedge clk);
        n_cmp++;
        if ({busy, txd} !== 2'b10) begin
            n_bad++;
            $display("FAIL rstmid_pre: got busy/txd=%b want 10", {busy, txd});
        end
        d0 = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({txd, busy, tx_done} !== 3'b100) begin
            n_bad++;
            $display("FAIL rstmid_post: got txd/busy/done=%b want 100", {txd, busy, tx_done});
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_quiet: got done=%0d busy=%b want 0 0", done_cnt - d0, busy);
        end
        start_fast(StrShort, 6'd3);
        for (int j = 0; j < 3; j++) begin
            rx_frame(-1, bits);
            n_cmp++;
            if (bits !== {1'b1, exp[j], 1'b0}) begin
                n_bad++;
                $display("FAIL rstmid_frame%0d: got %b want %b", j, bits, {1'b1, exp[j], 1'b0});
            end
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [9:0] bits;
        start_fast(StrShort, 6'd1);
        rx_frame(-1, bits);
        n_cmp++;
        if (bits !== {1'b1, 8'h23, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_frame0: got %b want %b", bits, {1'b1, 8'h23, 1'b0});
        end
        n_cmp++;
        if (tx_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_done0: got tx_done=%b want 1", tx_done);
        end
        start_fast(80'h41, 6'd1);
        n_cmp++;
        if ({txd, busy, tx_done} !== 3'b010) begin
            n_bad++;
            $display("FAIL b2b_restart: got txd/busy/done=%b want 010", {txd, busy, tx_done});
        end
        rx_frame(-1, bits);
        n_cmp++;
        if (bits !== {1'b1, 8'h41, 1'b0} || tx_done !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_frame1: got %b done=%b want %b done=1",
                     bits, tx_done, {1'b1, 8'h41, 1'b0});
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_slow_baud();
        logic [9:0] bits;
        logic [7:0] exp [3];
        logic       prev;
        int         last_edge, iv, min_iv, bad_iv;
        exp       = '{8'h2A, 8'h31, 8'h23};
        bits      = '0;
        last_edge = 0;
        min_iv    = 1000000;
        bad_iv    = 0;
        read_data = StrShort;
        nummax    = 6'd3;
        en_slow   = 1'b1;
        @(negedge clk);
        en_slow = 1'b0;
        prev    = txd_s;
        for (int t = 0; t < 30 * DivSlow; t++) begin
            if (t > 0 && txd_s !== prev) begin
                iv = t - last_edge;
                if (iv % DivSlow != 0) bad_iv++;
                if (iv < min_iv) min_iv = iv;
                last_edge = t;
                prev      = txd_s;
            end
            if (t % DivSlow == DivSlow / 2) bits[(t % (10 * DivSlow)) / DivSlow] = txd_s;
            if (t % (10 * DivSlow) == 10 * DivSlow - 1) begin
                n_cmp++;
                if (bits !== {1'b1, exp[t / (10 * DivSlow)], 1'b0}) begin
                    n_bad++;
                    $display("FAIL slow_frame%0d: got %b want %b", t / (10 * DivSlow), bits,
                             {1'b1, exp[t / (10 * DivSlow)], 1'b0});
                end
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bad_iv != 0 || min_iv != DivSlow) begin
            n_bad++;
            $display("FAIL slow_period: got bad_edges=%0d min_period=%0d want 0 and %0d",
                     bad_iv, min_iv, DivSlow);
        end
        n_cmp++;
        if ({busy_s, done_s, txd_s} !== 3'b011) begin
            n_bad++;
            $display("FAIL slow_end: got busy/done/txd=%b want 011", {busy_s, done_s, txd_s});
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_short_string();
        run_long(6'd10, "long");
        test_ignore_inputs();
        test_zero_and_clamp();
        test_reset_mid();
        test_back_to_back();
        test_slow_baud();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_str_tx.md
# uart_str_tx

UART string transmitter for the test-fixture FPGA: sends a short ASCII message (status or ID string such as "*A08-2_V4#", "*1#", "*0#") to the PC over a single TX line. The button/pattern control logic drives it with a start pulse, an 80-bit packed string and a byte count. Frames are 8N1, LSB first, with an integer clock-cycles-per-bit divider.

## Interface
Parameters:
- CLK_DIV, 703: clock cycles per bit; 81 MHz / 115200 baud. Legal range 2..65535.
- MAX_BYTES, 10: capacity of the string register in bytes. The data width is 8*MAX_BYTES.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous reset, active-high.
- en_uart  in  1  start request, sampled every cycle. Acted on only while idle.
- read_data  in  80  packed string, right-aligned. The first character is at bits [8*nummax-1 -: 8]; the last character is at [7:0].
- nummax  in  6  number of bytes to send. 0 = no transmission; values above MAX_BYTES are clamped to MAX_BYTES.
- txd  out  1  serial output. Idle level is 1.
- busy  out  1  high from the cycle after an accepted start until the last stop bit ends.
- tx_done  out  1  one-cycle pulse when the whole string has been sent.

## Operation
- Reset values: txd=1, busy=0, tx_done=0. The FSM enters IDLE and all counters are cleared.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On en_uart=1 with clamped nummax≠0: latch read_data into the shift/string register, load byte_cnt = clamped nummax, select byte index byte_cnt-1, then go to START.
  - en_uart=1 with nummax=0: ignored. busy and tx_done stay 0.
- START: txd=0 for CLK_DIV cycles, then DATA with bit_idx=0.
- DATA:
  - txd = current byte[bit_idx] for CLK_DIV cycles per bit.
  - After bit 7, go to STOP.
- STOP: txd=1 for CLK_DIV cycles. Then:
  - If bytes remain: decrement byte_cnt, select the next lower byte, go straight to START. There is no inter-byte gap.
  - Otherwise: pulse tx_done and return to IDLE.
- Inputs are ignored while busy=1:
  - en_uart pulses are dropped, not queued.
  - Changes on read_data and nummax do not affect the string in flight.
- Divider: a baud counter runs 0..CLK_DIV-1 and wraps. Its width is clog2(CLK_DIV).
- Bit timing is exact: no fractional accumulation and no drift across bytes.
- Reset mid-transmission: on the next edge txd=1, busy=0, tx_done=0. The partial frame is truncated and no done pulse is issued.

## Timing
- en_uart sampled high at edge N, in IDLE → at edge N+1, busy=1 and txd=0 (start bit begins).
- Each frame lasts 10*CLK_DIV cycles. The whole string lasts nummax*10*CLK_DIV cycles, measured from the first txd fall.
- At the edge that ends the final stop bit, in the same cycle:
  - busy falls to 0;
  - tx_done=1 for exactly one cycle;
  - txd remains 1.
- A new en_uart is accepted in the cycle tx_done is high: the FSM is already in IDLE. Its start bit appears on the following edge.
- en_uart held high continuously re-triggers immediately after each string. This is legal, and the upstream logic is responsible for pulsing.
- Outputs are registered. There is no combinational path from en_uart to txd.

## Test plan
- Run with CLK_DIV=4, read_data="*1#" (0x2A3123 in [23:0]), nummax=3, and a one-cycle en_uart.
  - Required: txd carries 0x2A, 0x31, 0x23 in that order, LSB first, with a start and stop bit per byte.
  - Frame boundaries at 40-cycle steps.
  - busy high for 120 cycles; one tx_done pulse.
- Send "*A08-2_V4#" with nummax=10.
  - Required: 10 bytes in order, first '*' (0x2A), last '#' (0x23), 400 cycles total.
- Pulse en_uart again 50 cycles into the string, and change read_data mid-string.
  - Required: the transmitted bytes are unchanged and there is no second transmission.
- Start with nummax=0, and separately with nummax=20 and a full 10-char string.
  - nummax=0: no txd activity, busy=0, no tx_done.
  - nummax=20: clamped to 10 bytes.
- Assert rst for one cycle mid-DATA of byte 2.
  - Required: txd=1 and busy=0 on the next edge, no tx_done.
  - A subsequent start transmits normally from byte 1.
- Set CLK_DIV=703 and decode txd with a reference UART model at 81 MHz / 115200.
  - Required: bytes decode error-free; measured bit period is 703 cycles ±0.
